spectrum_magnitude_streamer: RTL
================================

Name: spectrum_magnitude_streamer

Overview:
- Sits between the FFT output bin RAM and the serial peak finder in the pitch-detection path.
- On each completed FFT frame, it reads bins 0..NUM_BINS-1 and computes squared magnitude re²+im², scaled and saturated to 18 bits.
- Emits one magnitude per cycle as a contiguous burst with the start/enable framing the peak finder consumes.
- Bin N of the burst is always the N-th enabled datum.

Parameters:
- ADDR_W, 12, bin RAM address width.
- NUM_BINS, 2048, bins streamed per frame (lower half of a 4096-point FFT); must satisfy 2 ≤ NUM_BINS ≤ 2^ADDR_W.
- IN_W, 16, width of signed real/imag bin components.
- MEM_LATENCY, 2, bin RAM read latency in cycles (address to data); valid range 1..4.
- SHIFT, 13, right shift applied to the 2*IN_W+1-bit sum of squares before saturation.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_ready  in  1  1-cycle pulse from FFT: bin RAM holds a complete frame
- rd_addr  out  ADDR_W  bin RAM read address
- rd_re  in  IN_W  signed real part, valid MEM_LATENCY cycles after rd_addr
- rd_im  in  IN_W  signed imaginary part, same timing as rd_re
- busy  out  1  high from frame accept until frame_done inclusive
- mag_start  out  1  1-cycle pulse coincident with bin 0 magnitude
- mag_enable  out  1  high for exactly NUM_BINS consecutive cycles, one per valid magnitude
- mag_data  out  18  unsigned scaled magnitude
- frame_done  out  1  1-cycle pulse the cycle after the last magnitude
- overrun  out  1  sticky: frame_ready arrived while busy

Behaviour:
- Reset: all outputs 0, FSM to IDLE, address counter 0, pipeline valid bits cleared. A reset mid-frame aborts the burst immediately: no further mag_enable and no frame_done. Reset applies to every register, including data pipeline registers.
- FSM states:
  - IDLE: on frame_ready, go to READ; rd_addr=0; busy rises next cycle.
  - READ: issue rd_addr 0,1,…,NUM_BINS-1 on consecutive cycles, no gaps. After issuing NUM_BINS-1, go to DRAIN.
  - DRAIN: wait until the last pipeline valid bit retires, then go to DONE.
  - DONE: frame_done=1 for one cycle, then IDLE. busy drops the cycle after DONE.
- Pipeline: address issued at cycle t; RAM data at t+MEM_LATENCY; squares registered at t+MEM_LATENCY+1; sum, shift and saturate registered at t+MEM_LATENCY+2 onto mag_data/mag_enable.
  - Total address-to-output latency = MEM_LATENCY+2.
  - frame_ready to mag_start = MEM_LATENCY+3 cycles.
- Valid shift register of depth MEM_LATENCY+2 tags issued addresses. mag_enable is its tail; mag_start is the tail ANDed with a first-bin tag.
- Arithmetic:
  - Signed×signed squares give unsigned 2*IN_W results; -32768² = 2^30 is exact.
  - Sum is 2*IN_W+1 bits and never overflows.
  - sum>>SHIFT; if the result exceeds 2^18-1, mag_data=262143.
- mag_data holds its last value when mag_enable=0; consumers must not rely on it.
- frame_ready while busy (including in the DONE cycle) is ignored, and overrun is set. overrun clears only on reset.
- frame_ready coincident with reset: reset wins; no frame starts.
- rd_addr holds its last value outside READ.

Optional Feature:
- Macro: SPECTRUM_DC_BLOCK_EN.
- Defined: magnitudes for bins 0 and 1 are forced to 0 at the output stage, so DC/LF leakage can never win the peak search. Framing, timing and counts are unchanged.
- Undefined: all bins pass unmodified.

Test Plan:
- Frame pulse, RAM with re=bin index, im=0, SHIFT=0, NUM_BINS=16, MEM_LATENCY=2 -> mag_start 5 cycles after frame_ready. Then 16 contiguous enables with mag_data 0,1,4,…,225. frame_done the cycle after bin 15. busy covers accept through done.
- Bin 7 re=-32768, im=-32768, SHIFT=13 -> sum 2^31, shifted 262144, mag_data=262143 (saturated). Bin 8 re=1000, im=0 -> 122.
- Second frame_ready 5 cycles into a burst -> burst unaffected (exactly 16 enables), overrun=1 and stays 1 through a later clean frame until reset.
- Reset asserted at the 6th enable cycle -> next cycle all outputs 0, no frame_done. A new frame_ready afterwards produces a full, correct burst.
- SPECTRUM_DC_BLOCK_EN defined, bins 0/1 hold max values -> mag_data 0 for first two enables, others unchanged. Undefined -> bins 0/1 saturate to 262143.
- Back-to-back frames, frame_ready one cycle after frame_done -> accepted with overrun=0. Two bursts of exactly NUM_BINS enables each.

Source files
------------

// File: rtl/spectrum_magnitude_streamer.sv
// Streams re^2+im^2 of every FFT bin as one contiguous, framed burst for the peak finder.
// Optional SPECTRUM_DC_BLOCK_EN forces the bin 0/1 magnitudes to zero without changing framing.
module spectrum_magnitude_streamer #(
  parameter int ADDR_W      = 12,
  parameter int NUM_BINS    = 2048,
  parameter int IN_W        = 16,
  parameter int MEM_LATENCY = 2,
  parameter int SHIFT       = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_ready,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic signed [IN_W-1:0] rd_re,
  input  logic signed [IN_W-1:0] rd_im,
  output logic                   busy,
  output logic                   mag_start,
  output logic                   mag_enable,
  output logic [17:0]            mag_data,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int MAG_W  = 18;
  localparam int SQ_W   = 2 * IN_W;
  localparam int SUM_W  = SQ_W + 1;
  localparam int PIPE_D = MEM_LATENCY + 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);
  localparam logic [MAG_W-1:0]  MAG_MAX   = {MAG_W{1'b1}};
  localparam logic [SUM_W-1:0]  SAT_MAX   = SUM_W'(MAG_MAX);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t state;

  logic              accept;
  logic              issue;
  logic [PIPE_D-1:0] vld_pipe;
  logic [PIPE_D-1:0] first_pipe;

  logic signed [SQ_W-1:0] re_sq;
  logic signed [SQ_W-1:0] im_sq;
  logic [SQ_W-1:0]        sq_re;
  logic [SQ_W-1:0]        sq_im;
  logic [SUM_W-1:0]       sum_c;
  logic [SUM_W-1:0]       shifted_c;
  logic [MAG_W-1:0]       mag_c;
  logic [MAG_W-1:0]       mag_out;

`ifdef SPECTRUM_DC_BLOCK_EN
  logic              issue_low;
  logic [PIPE_D-1:0] low_pipe;
`endif

  // A new address enters the RAM whenever the frame is accepted or READ advances.
  always_comb begin
    accept = (state == IDLE) && frame_ready;
    issue  = accept || ((state == READ) && (rd_addr != LAST_ADDR));
`ifdef SPECTRUM_DC_BLOCK_EN
    issue_low = accept || ((state == READ) && (rd_addr == '0));
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_addr    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_ready && (state != IDLE))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_ready) begin
            state   <= READ;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        READ: begin
          if (rd_addr == LAST_ADDR)
            state <= DRAIN;
          else
            rd_addr <= rd_addr + ADDR_W'(1);
        end
        DRAIN: begin
          // Empty tag pipe means the last magnitude is on the output this cycle.
          if (vld_pipe == '0) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sign-extend before multiplying; the low SQ_W bits of the product are the exact square.
  always_comb begin
    re_sq     = SQ_W'(rd_re) * SQ_W'(rd_re);
    im_sq     = SQ_W'(rd_im) * SQ_W'(rd_im);
    sum_c     = {1'b0, sq_re} + {1'b0, sq_im};
    shifted_c = sum_c >> SHIFT;
    mag_c     = (shifted_c > SAT_MAX) ? MAG_MAX : shifted_c[MAG_W-1:0];
`ifdef SPECTRUM_DC_BLOCK_EN
    mag_out   = low_pipe[PIPE_D-1] ? '0 : mag_c;
`else
    mag_out   = mag_c;
`endif
  end

  // NOTE: the data pipeline registers are reset too, so an aborted frame
  // leaves no stale squares or magnitudes behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      sq_re      <= '0;
      sq_im      <= '0;
      mag_enable <= 1'b0;
      mag_start  <= 1'b0;
      mag_data   <= '0;
`ifdef SPECTRUM_DC_BLOCK_EN
      low_pipe   <= '0;
`endif
    end else begin
      vld_pipe   <= {vld_pipe[PIPE_D-2:0], issue};
      first_pipe <= {first_pipe[PIPE_D-2:0], accept};
`ifdef SPECTRUM_DC_BLOCK_EN
      low_pipe   <= {low_pipe[PIPE_D-2:0], issue_low};
`endif
      // Tag bit MEM_LATENCY lines up with RAM data for the same address.
      if (vld_pipe[PIPE_D-2]) begin
        sq_re <= re_sq;
        sq_im <= im_sq;
      end
      mag_enable <= vld_pipe[PIPE_D-1];
      mag_start  <= vld_pipe[PIPE_D-1] & first_pipe[PIPE_D-1];
      if (vld_pipe[PIPE_D-1])
        mag_data <= mag_out;
    end
  end

endmodule
